// File: rtl/bus_sequencer_if.sv
// Control/handshake bundle between the bus sequencer and the datapath it steers.
interface bus_sequencer_if;
    logic [31:0] ir;
    logic        mem_ack;
    logic        pco, iro, maro, mdro, r0o, r1o;
    logic        pcin, irin, marin, mdrin, r0in, r1in;
    logic        pc_inc;
    logic        mdr_sel_mem;
    logic        mem_rd, mem_wr;
    logic        halted;
    logic [3:0]  state;

    modport master (
        input  ir, mem_ack,
        output pco, iro, maro, mdro, r0o, r1o,
        output pcin, irin, marin, mdrin, r0in, r1in,
        output pc_inc, mdr_sel_mem, mem_rd, mem_wr, halted, state
    );

    modport slave (
        output ir, mem_ack,
        input  pco, iro, maro, mdro, r0o, r1o,
        input  pcin, irin, marin, mdrin, r0in, r1in,
        input  pc_inc, mdr_sel_mem, mem_rd, mem_wr, halted, state
    );
endinterface

// File: rtl/bus_sequencer.sv
// Fetch/decode/execute sequencer for the single-bus datapath; sole driver of all
// bus source enables, register load strobes and the memory handshake.
module bus_sequencer (
    input  logic            clk,
    input  logic            rst,
    bus_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        StF0   = 4'd0,
        StF1   = 4'd1,
        StF2   = 4'd2,
        StEx   = 4'd3,
        StLd1  = 4'd4,
        StLd2  = 4'd5,
        StSt1  = 4'd6,
        StSt2  = 4'd7,
        StHalt = 4'd8
    } state_e;

    localparam logic [4:0] OpNop  = 5'd0;
    localparam logic [4:0] OpLd   = 5'd1;
    localparam logic [4:0] OpSt   = 5'd2;
    localparam logic [4:0] OpMov  = 5'd3;
    localparam logic [4:0] OpJmp  = 5'd4;
    localparam logic [4:0] OpHalt = 5'd5;

    state_e     state_q, state_d;
    logic [4:0] opcode;
    logic       rsel;

    assign opcode = bus.ir[31:27];
    assign rsel   = bus.ir[26];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StF0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.pco         = 1'b0;
        bus.iro         = 1'b0;
        bus.maro        = 1'b0;
        bus.mdro        = 1'b0;
        bus.r0o         = 1'b0;
        bus.r1o         = 1'b0;
        bus.pcin        = 1'b0;
        bus.irin        = 1'b0;
        bus.marin       = 1'b0;
        bus.mdrin       = 1'b0;
        bus.r0in        = 1'b0;
        bus.r1in        = 1'b0;
        bus.pc_inc      = 1'b0;
        bus.mdr_sel_mem = 1'b0;
        bus.mem_rd      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.halted      = 1'b0;
        bus.state       = state_q;

        unique case (state_q)
            StF0: begin
                bus.pco    = 1'b1;
                bus.marin  = 1'b1;
                bus.pc_inc = 1'b1;
                state_d    = StF1;
            end
            StF1: begin
                bus.mem_rd      = 1'b1;
                bus.mdr_sel_mem = 1'b1;
                bus.mdrin       = bus.mem_ack;
                if (bus.mem_ack) state_d = StF2;
            end
            StF2: begin
                bus.mdro = 1'b1;
                bus.irin = 1'b1;
                state_d  = StEx;
            end
            StEx: begin
                // IR was loaded at the F2 edge, so the live input is already the new word.
                state_d = StF0;
                case (opcode)
                    OpLd: begin
                        bus.iro   = 1'b1;
                        bus.marin = 1'b1;
                        state_d   = StLd1;
                    end
                    OpSt: begin
                        bus.iro   = 1'b1;
                        bus.marin = 1'b1;
                        state_d   = StSt1;
                    end
                    OpMov: begin
                        bus.r0o  = ~rsel;
                        bus.r1in = ~rsel;
                        bus.r1o  = rsel;
                        bus.r0in = rsel;
                    end
                    OpJmp: begin
                        bus.iro  = 1'b1;
                        bus.pcin = 1'b1;
                    end
                    OpHalt:  state_d = StHalt;
                    OpNop:   state_d = StF0;
                    default: state_d = StF0;
                endcase
            end
            StLd1: begin
                bus.mem_rd      = 1'b1;
                bus.mdr_sel_mem = 1'b1;
                bus.mdrin       = bus.mem_ack;
                if (bus.mem_ack) state_d = StLd2;
            end
            StLd2: begin
                bus.mdro = 1'b1;
                bus.r0in = ~rsel;
                bus.r1in = rsel;
                state_d  = StF0;
            end
            StSt1: begin
                bus.r0o   = ~rsel;
                bus.r1o   = rsel;
                bus.mdrin = 1'b1;
                state_d   = StSt2;
            end
            StSt2: begin
                bus.mem_wr = 1'b1;
                if (bus.mem_ack) state_d = StF0;
            end
            StHalt: begin
                bus.halted = 1'b1;
            end
            default: state_d = StF0;
        endcase

        // Reset silences everything in the same cycle, including pending memory requests.
        if (rst) begin
            bus.pco         = 1'b0;
            bus.iro         = 1'b0;
            bus.maro        = 1'b0;
            bus.mdro        = 1'b0;
            bus.r0o         = 1'b0;
            bus.r1o         = 1'b0;
            bus.pcin        = 1'b0;
            bus.irin        = 1'b0;
            bus.marin       = 1'b0;
            bus.mdrin       = 1'b0;
            bus.r0in        = 1'b0;
            bus.r1in        = 1'b0;
            bus.pc_inc      = 1'b0;
            bus.mdr_sel_mem = 1'b0;
            bus.mem_rd      = 1'b0;
            bus.mem_wr      = 1'b0;
            bus.halted      = 1'b0;
            bus.state       = 4'd0;
        end
    end
endmodule

// File: tb/tb_bus_sequencer.sv
// Randomized instruction-level bench: each instruction expands into its expected cycle trace.
module tb_bus_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_sequencer_if bif ();

    bus_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    localparam logic [16:0] M_PCO    = 17'h1 << 16;
    localparam logic [16:0] M_IRO    = 17'h1 << 15;
    localparam logic [16:0] M_MARO   = 17'h1 << 14;
    localparam logic [16:0] M_MDRO   = 17'h1 << 13;
    localparam logic [16:0] M_R0O    = 17'h1 << 12;
    localparam logic [16:0] M_R1O    = 17'h1 << 11;
    localparam logic [16:0] M_PCIN   = 17'h1 << 10;
    localparam logic [16:0] M_IRIN   = 17'h1 << 9;
    localparam logic [16:0] M_MARIN  = 17'h1 << 8;
    localparam logic [16:0] M_MDRIN  = 17'h1 << 7;
    localparam logic [16:0] M_R0IN   = 17'h1 << 6;
    localparam logic [16:0] M_R1IN   = 17'h1 << 5;
    localparam logic [16:0] M_PCINC  = 17'h1 << 4;
    localparam logic [16:0] M_MDRSEL = 17'h1 << 3;
    localparam logic [16:0] M_MEMRD  = 17'h1 << 2;
    localparam logic [16:0] M_MEMWR  = 17'h1 << 1;
    localparam logic [16:0] M_HALTED = 17'h1;

    typedef struct {
        bit          r;
        bit          a;
        logic [31:0] ir;
        logic [16:0] e;
    } ent_t;

    ent_t        q[$];
    logic [16:0] exp_v;
    logic [16:0] dut_v;
    bit          chk = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    int          wr_run, wr_max, halt_cnt;

    assign dut_v = {bif.pco, bif.iro, bif.maro, bif.mdro, bif.r0o, bif.r1o,
                    bif.pcin, bif.irin, bif.marin, bif.mdrin, bif.r0in, bif.r1in,
                    bif.pc_inc, bif.mdr_sel_mem, bif.mem_rd, bif.mem_wr, bif.halted};

    always @(negedge clk) begin
        if (chk) begin
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL outputs t=%0t ir=%h ack=%b rst=%b got=%b want=%b",
                         $time, bif.ir, bif.mem_ack, rst, dut_v, exp_v);
            end
            if ($countones({bif.pco, bif.iro, bif.maro, bif.mdro, bif.r0o, bif.r1o}) > 1) begin
                miscompares++;
                $display("FAIL bus_onehot t=%0t got=%b want=at most one", $time, dut_v[16:11]);
            end
            if (bif.mem_rd && bif.mem_wr) begin
                miscompares++;
                $display("FAIL rd_wr_excl t=%0t got=11 want=not both", $time);
            end
            if (bif.pcin && bif.pc_inc) begin
                miscompares++;
                $display("FAIL pcin_pcinc t=%0t got=11 want=not both", $time);
            end
        end
    end

    function automatic void push(bit r, bit a, logic [31:0] ir, logic [16:0] e);
        ent_t x;
        x.r = r; x.a = a; x.ir = ir; x.e = e;
        q.push_back(x);
    endfunction

    function automatic bit rnd_bit();
        return bit'($urandom_range(0, 1));
    endfunction

    // Appends the full expected trace of one instruction; returns its cycle count.
    function automatic int push_instr(logic [31:0] ir, int d_f, int d_m, int halt_n);
        int          n0 = q.size();
        logic [4:0]  op = ir[31:27];
        bit          rs = ir[26];
        push(0, rnd_bit(), ir, M_PCO | M_MARIN | M_PCINC);
        for (int i = 0; i < d_f; i++) push(0, 0, ir, M_MEMRD | M_MDRSEL);
        push(0, 1, ir, M_MEMRD | M_MDRSEL | M_MDRIN);
        push(0, rnd_bit(), ir, M_MDRO | M_IRIN);
        case (op)
            5'd1: begin
                push(0, rnd_bit(), ir, M_IRO | M_MARIN);
                for (int i = 0; i < d_m; i++) push(0, 0, ir, M_MEMRD | M_MDRSEL);
                push(0, 1, ir, M_MEMRD | M_MDRSEL | M_MDRIN);
                push(0, rnd_bit(), ir, M_MDRO | (rs ? M_R1IN : M_R0IN));
            end
            5'd2: begin
                push(0, rnd_bit(), ir, M_IRO | M_MARIN);
                push(0, rnd_bit(), ir, (rs ? M_R1O : M_R0O) | M_MDRIN);
                for (int i = 0; i < d_m; i++) push(0, 0, ir, M_MEMWR);
                push(0, 1, ir, M_MEMWR);
            end
            5'd3: push(0, rnd_bit(), ir, rs ? (M_R1O | M_R0IN) : (M_R0O | M_R1IN));
            5'd4: push(0, rnd_bit(), ir, M_IRO | M_PCIN);
            5'd5: begin
                push(0, rnd_bit(), ir, '0);
                for (int i = 0; i < halt_n; i++) push(0, rnd_bit(), ir, M_HALTED);
            end
            default: push(0, rnd_bit(), ir, '0);
        endcase
        return q.size() - n0;
    endfunction

    function automatic void push_reset(int n);
        for (int i = 0; i < n; i++) push(1, rnd_bit(), 32'h0, '0);
    endfunction

    task automatic run_q();
        ent_t x;
        wr_run = 0; wr_max = 0; halt_cnt = 0;
        while (q.size() > 0) begin
            x = q.pop_front();
            rst         = x.r;
            bif.mem_ack = x.a;
            bif.ir      = x.ir;
            exp_v       = x.e;
            chk         = 1'b1;
            @(negedge clk);
            wr_run   = bif.mem_wr ? wr_run + 1 : 0;
            if (wr_run > wr_max) wr_max = wr_run;
            if (bif.halted) halt_cnt++;
            @(posedge clk);
            #1;
        end
        chk = 1'b0;
    endtask

    task automatic check_int(string name, int got, int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    initial begin
        int          n;
        logic [31:0] ir;
        int          keep;
        rst = 1'b1;
        bif.mem_ack = 1'b0;
        bif.ir = 32'h0;
        @(posedge clk);
        #1;
        push_reset(2);
        run_q();

        n = push_instr(32'h0000_0000, 0, 0, 0);
        check_int("nop_len", n, 4);
        void'(push_instr(32'h0000_0000, 0, 0, 0));
        void'(push_instr(32'h0000_0000, 0, 0, 0));
        run_q();

        n = push_instr(32'h0C00_0010, 0, 0, 0);
        check_int("ld_len", n, 6);
        run_q();

        n = push_instr(32'h1000_0020, 0, 3, 0);
        check_int("st_len", n, 9);
        run_q();
        check_int("st_memwr_run", wr_max, 4);

        void'(push_instr(32'h1800_0000, 0, 0, 0));
        void'(push_instr(32'h1C00_0000, 0, 0, 0));
        void'(push_instr(32'h2000_0040, 1, 0, 0));
        void'(push_instr(32'hF800_0000, 0, 0, 0));
        run_q();

        // Random instruction mix with random wait states and occasional mid-instruction reset.
        for (int k = 0; k < 150; k++) begin
            ir = $urandom;
            if (ir[31:27] == 5'd5) ir[31:27] = 5'd1;
            if ($urandom_range(0, 1) == 1) ir[31:27] = 5'($urandom_range(0, 4));
            n = push_instr(ir, $urandom_range(0, 3), $urandom_range(0, 3), 0);
            if ($urandom_range(0, 9) == 0) begin
                keep = $urandom_range(1, n - 1);
                while (q.size() > keep) void'(q.pop_back());
                push_reset($urandom_range(1, 2));
            end
            run_q();
        end

        n = push_instr(32'h2800_0000, 0, 0, 20);
        check_int("halt_len", n, 24);
        run_q();
        check_int("halt_cycles", halt_cnt, 20);
        push_reset(1);
        void'(push_instr(32'h0000_0000, 0, 0, 0));
        run_q();
        check_int("after_halt_cycles", halt_cnt, 0);

        // Reset while F1 is waiting for memory.
        void'(push_instr(32'h0000_0000, 10, 0, 0));
        while (q.size() > 6) void'(q.pop_back());
        push_reset(1);
        void'(push_instr(32'h0C00_0000, 0, 1, 0));
        run_q();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
